// File: rtl/number_loader.sv
// number_loader: host-side writer for the sorter's number-entry inputs.
// Takes four 4-bit values over a valid/ready handshake. Each value is written
// into its sorter slot with a one-cycle strobe on partC, the value on partA and
// the one-hot slot select on partB. After the fourth write and a short settle
// delay, partD is pulsed to start the sort. The block then parks in DONE until
// restart is seen.
module number_loader #(
  parameter int unsigned SETTLE_CYC = 2,  // idle cycles between last strobe and sort start (1..15)
  parameter int unsigned SORT_PULSE = 3   // cycles partD is held high (1..15)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  output logic       in_ready,
  input  logic       restart,
  output logic [3:0] partA,
  output logic [3:0] partB,
  output logic       partC,
  output logic       partD,
  output logic       busy,
  output logic       done,
  output logic [1:0] slot_idx
);

  // Terminal counts. Each counter starts at zero on entry to its state, so the
  // last cycle of the state is the one where the counter reads N-1.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);
  localparam logic [3:0] PULSE_LAST  = 4'(SORT_PULSE - 1);

  typedef enum logic [2:0] {
    S_LOAD,
    S_WRITE,
    S_SETTLE,
    S_SORT,
    S_DONE
  } state_t;

  state_t     state_q;
  logic [3:0] settle_cnt_q;
  logic [3:0] pulse_cnt_q;
  logic [1:0] slot_q;
  logic [3:0] partA_q;      // doubles as the captured-value register
  logic [3:0] partB_q;
  logic       partC_q;
  logic       partD_q;
  logic       in_ready_q;
  logic       busy_q;
  logic       done_q;

  // Controller state and all registered outputs. Reset wins over everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_LOAD;
      settle_cnt_q <= '0;
      pulse_cnt_q  <= '0;
      slot_q       <= '0;
      partA_q      <= '0;
      partB_q      <= '0;
      partC_q      <= 1'b0;
      partD_q      <= 1'b0;
      in_ready_q   <= 1'b0;   // raised on the first cycle after reset
      busy_q       <= 1'b1;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          // Acceptance uses the registered ready, so the first cycle after
          // reset cannot accept even with in_valid already high.
          if (in_valid && in_ready_q) begin
            partA_q    <= in_data;
            partB_q    <= 4'b0001 << slot_q;
            partC_q    <= 1'b1;
            in_ready_q <= 1'b0;
            state_q    <= S_WRITE;
          end else begin
            in_ready_q <= 1'b1;
          end
        end

        S_WRITE: begin
          // Strobe lasts exactly this one cycle; partB drops with it while
          // partA keeps the last written value.
          partC_q <= 1'b0;
          partB_q <= '0;
          if (slot_q == 2'd3) begin
            slot_q       <= '0;
            settle_cnt_q <= '0;
            in_ready_q   <= 1'b0;
            state_q      <= S_SETTLE;
          end else begin
            slot_q     <= slot_q + 2'd1;
            in_ready_q <= 1'b1;
            state_q    <= S_LOAD;
          end
        end

        S_SETTLE: begin
          if (settle_cnt_q == SETTLE_LAST) begin
            partD_q     <= 1'b1;
            pulse_cnt_q <= '0;
            state_q     <= S_SORT;
          end else begin
            settle_cnt_q <= settle_cnt_q + 4'd1;
          end
        end

        S_SORT: begin
          if (pulse_cnt_q == PULSE_LAST) begin
            partD_q <= 1'b0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end else begin
            pulse_cnt_q <= pulse_cnt_q + 4'd1;
          end
        end

        S_DONE: begin
          // in_valid is ignored here; only restart leaves DONE.
          if (restart) begin
            done_q     <= 1'b0;
            busy_q     <= 1'b1;
            in_ready_q <= 1'b1;
            state_q    <= S_LOAD;
          end
        end

        default: begin
          state_q    <= S_LOAD;
          partC_q    <= 1'b0;
          partD_q    <= 1'b0;
          partB_q    <= '0;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b1;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

  assign partA    = partA_q;
  assign partB    = partB_q;
  assign partC    = partC_q;
  assign partD    = partD_q;
  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign slot_idx = slot_q;

endmodule

// File: tb/tb_number_loader.sv
// Directed bench for number_loader: default-parameter instance plus a
// SETTLE_CYC=1 / SORT_PULSE=1 instance sharing the same stimulus.
module tb_number_loader;
  logic clk = 1'b0;
  logic rst_n, in_valid, restart;
  logic [3:0] in_data;

  logic       in_ready, partC, partD, busy, done;
  logic [3:0] partA, partB;
  logic [1:0] slot_idx;

  logic       in_ready2, partC2, partD2, busy2, done2;
  logic [3:0] partA2, partB2;
  logic [1:0] slot_idx2;

  int total = 0;
  int bad   = 0;

  // pulse counters for the default instance
  int strobes = 0;
  int dpulses = 0;
  logic partD_prev = 1'b0;

  always #5 clk = ~clk;

  number_loader dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .restart(restart), .partA(partA), .partB(partB),
    .partC(partC), .partD(partD), .busy(busy), .done(done), .slot_idx(slot_idx)
  );

  number_loader #(.SETTLE_CYC(1), .SORT_PULSE(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready2), .restart(restart), .partA(partA2), .partB(partB2),
    .partC(partC2), .partD(partD2), .busy(busy2), .done(done2), .slot_idx(slot_idx2)
  );

  always @(negedge clk) begin
    strobes    <= strobes + (partC ? 1 : 0);
    dpulses    <= dpulses + ((partD && !partD_prev) ? 1 : 0);
    partD_prev <= partD;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present v, wait for ready (bounded), let it be accepted, check the strobe.
  // in_valid is left high so consecutive calls run back to back.
  task automatic send(input int v, input int expb, input string tag);
    in_valid = 1'b1;
    in_data  = 4'(v);
    for (int k = 0; k < 20 && !in_ready; k++) tick();
    chk({tag, "_ready"}, int'(in_ready), 1);
    tick();
    chk({tag, "_C"}, int'(partC), 1);
    chk({tag, "_A"}, int'(partA), v);
    chk({tag, "_B"}, int'(partB), expb);
    chk({tag, "_D"}, int'(partD), 0);
    chk({tag, "_rdy0"}, int'(in_ready), 0);
  endtask

  task automatic wait_done(input string tag);
    for (int k = 0; k < 40 && !done; k++) tick();
    chk({tag, "_done"}, int'(done), 1);
  endtask

  int s0, d0;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; restart = 1'b0; in_data = 4'd0;

    // ---- reset state
    tick();
    chk("rst_A", int'(partA), 0);
    chk("rst_B", int'(partB), 0);
    chk("rst_C", int'(partC), 0);
    chk("rst_D", int'(partD), 0);
    chk("rst_ready", int'(in_ready), 0);
    chk("rst_busy", int'(busy), 1);
    chk("rst_done", int'(done), 0);
    chk("rst_slot", int'(slot_idx), 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", int'(in_ready), 1);

    // ---- full batch back to back: 9,3,12,5
    send(9, 1, "b2b0");
    tick(); chk("b2b0_gap_C", int'(partC), 0); chk("b2b0_gap_B", int'(partB), 0);
    send(3, 2, "b2b1");
    tick(); chk("b2b1_gap_C", int'(partC), 0);
    send(12, 4, "b2b2");
    tick(); chk("b2b2_gap_C", int'(partC), 0);
    send(5, 8, "b2b3");
    in_valid = 1'b0;
    tick(); chk("b2b_w1_D", int'(partD), 0); chk("b2b_w1_B", int'(partB), 0);
    chk("b2b_w1_A", int'(partA), 5); chk("b2b_w1_slot", int'(slot_idx), 0);
    tick(); chk("b2b_w2_D", int'(partD), 0);
    tick(); chk("b2b_w3_D", int'(partD), 1); chk("b2b_w3_C", int'(partC), 0);
    tick(); chk("b2b_w4_D", int'(partD), 1);
    tick(); chk("b2b_w5_D", int'(partD), 1); chk("b2b_w5_done", int'(done), 0);
    tick(); chk("b2b_w6_D", int'(partD), 0); chk("b2b_w6_done", int'(done), 1);
    chk("b2b_w6_busy", int'(busy), 0); chk("b2b_w6_ready", int'(in_ready), 0);

    // ---- DONE ignores in_valid
    s0 = strobes;
    in_valid = 1'b1; in_data = 4'd7;
    tick(); tick(); tick();
    chk("ign_done", int'(done), 1);
    chk("ign_ready", int'(in_ready), 0);
    chk("ign_C", int'(partC), 0);
    chk("ign_strobes", strobes - s0, 0);
    in_valid = 1'b0;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("rst_ready1", int'(in_ready), 1);
    chk("rst_done0", int'(done), 0);
    chk("rst_busy1", int'(busy), 1);

    // ---- gapped valid, restart ignored in SETTLE
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b0;
      for (int g = 0; g < 4; g++) begin
        tick();
        chk("gap_C", int'(partC), 0);
        chk("gap_slot", int'(slot_idx), i);
      end
      send(i + 1, 1 << i, "gap");
    end
    in_valid = 1'b0;
    tick(); chk("gap_slot_wrap", int'(slot_idx), 0);
    restart = 1'b1;                          // in SETTLE: no effect
    tick(); restart = 1'b0;
    chk("settle_rs_D", int'(partD), 0); chk("settle_rs_busy", int'(busy), 1);
    chk("settle_rs_ready", int'(in_ready), 0);
    tick(); chk("settle_rs_D1", int'(partD), 1);
    tick(); tick(); tick();
    chk("settle_rs_done", int'(done), 1);

    // ---- reset mid-batch
    restart = 1'b1; tick(); restart = 1'b0;
    send(10, 1, "mid0"); tick();
    send(11, 2, "mid1"); in_valid = 1'b0; tick();
    rst_n = 1'b0;
    tick();
    chk("mid_rst_slot", int'(slot_idx), 0);
    chk("mid_rst_ready", int'(in_ready), 0);
    chk("mid_rst_C", int'(partC), 0);
    s0 = strobes; d0 = dpulses;
    rst_n = 1'b1;
    send(14, 1, "mid_n0"); tick();
    send(2, 2, "mid_n1"); tick();
    send(8, 4, "mid_n2"); tick();
    send(6, 8, "mid_n3"); in_valid = 1'b0;
    wait_done("mid");
    tick();
    chk("mid_strobes", strobes - s0, 4);
    chk("mid_dpulses", dpulses - d0, 1);

    // ---- reset during SORT
    restart = 1'b1; tick(); restart = 1'b0;
    send(1, 1, "srt0"); tick();
    send(2, 2, "srt1"); tick();
    send(3, 4, "srt2"); tick();
    send(4, 8, "srt3"); in_valid = 1'b0;
    for (int k = 0; k < 20 && !partD; k++) tick();
    chk("srt_D_first", int'(partD), 1);
    tick();
    chk("srt_D_second", int'(partD), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("srt_rst_D", int'(partD), 0);
    chk("srt_rst_done", int'(done), 0);
    chk("srt_rst_busy", int'(busy), 1);
    begin
      int dseen = 0, pseen = 0;
      for (int k = 0; k < 10; k++) begin
        tick();
        dseen += int'(done);
        pseen += int'(partD);
      end
      chk("srt_no_done", dseen, 0);
      chk("srt_no_D", pseen, 0);
    end
    chk("srt_load_ready", int'(in_ready), 1);

    // ---- parameter corner (dut2 in sync with dut since the reset above)
    chk("cor_ready", int'(in_ready2), 1);
    send(15, 1, "cor0"); tick();
    send(0, 2, "cor1"); tick();
    send(7, 4, "cor2"); tick();
    send(13, 8, "cor3"); in_valid = 1'b0;
    chk("cor_w_C2", int'(partC2), 1);
    chk("cor_w_B2", int'(partB2), 8);
    tick(); chk("cor_w1_D2", int'(partD2), 0);
    tick(); chk("cor_w2_D2", int'(partD2), 1); chk("cor_w2_C2", int'(partC2), 0);
    tick(); chk("cor_w3_D2", int'(partD2), 0); chk("cor_w3_done2", int'(done2), 1);
    chk("cor_w3_busy2", int'(busy2), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/number_loader.md
# number_loader

Host-side writer for the sorter's number-entry interface. Accepts four 4-bit values over a valid/ready handshake and writes each into its slot in the sorter's input stage: `partA` carries the value, `partB` the one-hot slot select, and `partC` the write strobe. After the fourth write and a settle delay, it pulses `partD` to start the sort, then reports completion. It sits between a host/testbench source and the top-level `partA..partD` inputs, replacing manual switch entry.

## Interface

Parameters:
- `SETTLE_CYC`, default 2: idle cycles between the last write strobe and the sort-start pulse. Legal range 1..15.
- `SORT_PULSE`, default 3: cycles `partD` is held high. Legal range 1..15.

Ports:
- `clk`, input, 1: sole clock; all logic on the rising edge.
- `rst_n`, input, 1: reset, synchronous and active-low.
- `in_valid`, input, 1: host presents a value.
- `in_data`, input, 4: value to load (unsigned 0..15).
- `in_ready`, output, 1: loader can accept a value this cycle.
- `restart`, input, 1: in DONE, begins a new 4-value load.
- `partA`, output, 4: value being written.
- `partB`, output, 4: one-hot slot select (bit i = slot i).
- `partC`, output, 1: write strobe, one cycle per value.
- `partD`, output, 1: sort-start pulse.
- `busy`, output, 1: high in every state except DONE.
- `done`, output, 1: level; high in DONE.
- `slot_idx`, output, 2: number of values already written in the current batch (0..3).

## Operation

- All outputs are registered.
- Reset (`rst_n`=0 at a clock edge) applies in any state, including mid-batch or mid-pulse. Reset values:
  - state=LOAD, `partA`=0, `partB`=0, `partC`=0, `partD`=0.
  - `in_ready`=0 for the reset cycle, then 1 in LOAD.
  - `busy`=1, `done`=0, `slot_idx`=0.
  - A partially written batch is abandoned; no `partC` or `partD` pulse follows reset.
- State machine:
  - **LOAD**
    - `in_ready`=1.
    - On `in_valid`&&`in_ready`: capture `in_data` into the value register, then go to WRITE.
    - Otherwise stay in LOAD.
  - **WRITE** (exactly 1 cycle)
    - `partC`=1, `partA`=captured value, `partB`=`4'b0001 << slot_idx`, `in_ready`=0.
    - If `slot_idx`==3: set `slot_idx` to 0 and go to SETTLE. Otherwise increment `slot_idx` and return to LOAD.
  - **SETTLE**
    - Count `SETTLE_CYC` cycles with `partC`=0, `partD`=0, `partB`=0. `partA` holds its last value.
    - Then go to SORT.
  - **SORT**
    - `partD`=1 for exactly `SORT_PULSE` consecutive cycles, then go to DONE.
  - **DONE**
    - `done`=1, `busy`=0, `in_ready`=0; `in_valid` is ignored.
    - `restart`=1 goes to LOAD.
- Width rules:
  - The settle and pulse counters are 4 bits.
  - `slot_idx` is 2 bits and wraps only via the explicit clear in WRITE.
- `partB` is all-zero whenever `partC`=0.
- `partC` and `partD` are never high in the same cycle.
- `restart` outside DONE is ignored.
- `in_valid` in WRITE, SETTLE or SORT is not accepted (`in_ready`=0); the host must hold the value until `in_ready` is high.

## Timing

- Acceptance at edge t puts `partC`=1 in cycle t+1, with `partA`/`partB` valid in that same cycle. `in_ready` returns high in cycle t+2.
- Peak rate is one value per 2 cycles, so a batch with `in_valid` held high takes 8 cycles from the first acceptance to the last strobe.
- With the last strobe in cycle w:
  - SETTLE occupies cycles w+1..w+`SETTLE_CYC`.
  - `partD`=1 in cycles w+`SETTLE_CYC`+1 .. w+`SETTLE_CYC`+`SORT_PULSE`.
  - `done` rises in the following cycle.
- `restart` sampled at edge r puts the block in LOAD with `in_ready`=1 in cycle r+1. `done` falls in the same cycle.
- Reset takes priority over `restart` and the handshake when they are asserted in the same cycle.

## Test plan

- **Full batch, back-to-back:** defaults; drive `in_data`=9,3,12,5 with `in_valid` held high.
  - Required: `partC` pulses with (`partA`,`partB`) = (9,0001), (3,0010), (12,0100), (5,1000), two cycles apart.
  - Required: `partD` high for 3 cycles starting 3 cycles after the last strobe, then `done`=1.
- **Gapped valid:** insert 4 idle cycles between values.
  - Required: one strobe per value, `slot_idx` steps 0→1→2→3→0, `partC` never high while `in_valid` is low in LOAD.
- **Reset mid-batch:** assert `rst_n`=0 after the 2nd strobe, release, then send 4 new values.
  - Required: the first new value is written to slot `0001`; exactly 4 strobes and 1 `partD` pulse occur after release.
- **Reset during SORT:** assert `rst_n`=0 in the 2nd cycle of `partD`.
  - Required: `partD`=0 on the next cycle, `done` never asserts, state is LOAD.
- **Restart and ignore rules:** in DONE, drive `in_valid`=1 with no `restart`.
  - Required: no acceptance.
  - Then pulse `restart`: `in_ready`=1 on the next cycle and the batch proceeds normally.
  - `restart` pulsed during SETTLE has no effect.
- **Parameter corners:** `SETTLE_CYC`=1 and `SORT_PULSE`=1.
  - Required: `partD` is high for exactly 1 cycle, 2 cycles after the last strobe.
